// File: rtl/traceback_walker.sv
// traceback_walker
// Control stage of the traceback datapath. Starting from cell (len_a, len_b),
// it reads one direction word per move from the direction memory. On the first
// row or column it uses a forced arrow instead of reading memory. It sends one
// {en_traceB, symbol} step per move to the processing stage, until it reaches
// cell (0,0). Each move takes 3 cycles: READ -> WAIT -> EMIT.

module traceback_walker #(
    parameter int N      = 128,
    parameter int IDX_W  = $clog2(N + 1),
    parameter int STEP_W = $clog2(2 * N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  len_a,
    input  logic [IDX_W-1:0]  len_b,
    output logic              dir_rd_en,
    output logic [IDX_W-1:0]  dir_addr_i,
    output logic [IDX_W-1:0]  dir_addr_j,
    input  logic [2:0]        dir_data,
    output logic [IDX_W-1:0]  seqA_addr,
    output logic [IDX_W-1:0]  seqB_addr,
    output logic              en_traceB,
    output logic [2:0]        symbol,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] step_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] ARROW_DIAG = 3'b001;
    localparam logic [2:0] ARROW_UP   = 3'b010;
    localparam logic [2:0] ARROW_LEFT = 3'b100;

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  i_q, i_d;
    logic [IDX_W-1:0]  j_q, j_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              en_q, en_d;
    logic [2:0]        sym_q, sym_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Arrow for the current cell. A move at a boundary is forced, so the
    // memory word is only used when both indices are non-zero.
    logic [2:0] wait_arrow;
    logic       arrow_legal;
    logic [IDX_W-1:0] i_next, j_next;

    // Select the arrow for this cell and check it. Also compute the indices after the move.
    always_comb begin
        if (i_q == '0) begin
            wait_arrow = ARROW_LEFT;
        end else if (j_q == '0) begin
            wait_arrow = ARROW_UP;
        end else begin
            wait_arrow = dir_data;
        end
        arrow_legal = (wait_arrow == ARROW_DIAG) || (wait_arrow == ARROW_UP) ||
                      (wait_arrow == ARROW_LEFT);
        // In EMIT, sym_q holds the arrow of the move in progress.
        i_next = (sym_q == ARROW_DIAG || sym_q == ARROW_UP)   ? i_q - IDX_W'(1) : i_q;
        j_next = (sym_q == ARROW_DIAG || sym_q == ARROW_LEFT) ? j_q - IDX_W'(1) : j_q;
    end

    // Next-state logic for the walk FSM and its datapath registers.
    always_comb begin
        // NOTE: every signal gets a default here before the case statement,
        // so no path leaves one unassigned. An unassigned path would infer a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        en_d    = 1'b0;
        sym_d   = 3'b000;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    i_d    = len_a;
                    j_d    = len_b;
                    step_d = '0;
                    err_d  = 1'b0;
                    if (len_a == '0 && len_b == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_READ;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!arrow_legal) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    // Register the step now, so EMIT presents it straight from flops.
                    en_d    = 1'b1;
                    sym_d   = wait_arrow;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                step_d = step_q + STEP_W'(1);
                i_d    = i_next;
                j_d    = j_next;
                if (i_next == '0 && j_next == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset returns to IDLE with every output cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            step_q  <= '0;
            en_q    <= 1'b0;
            sym_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: registers use non-blocking assignments. Every flop then
            // samples the values from before the edge, whatever order the statements are in.
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            step_q  <= step_d;
            en_q    <= en_d;
            sym_q   <= sym_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Memory interfaces. The sequence addresses follow the current cell in
    // every state, so ROM data is ready by EMIT.
    assign dir_rd_en  = (state_q == S_READ) && (i_q != '0) && (j_q != '0);
    assign dir_addr_i = i_q;
    assign dir_addr_j = j_q;
    assign seqA_addr  = (i_q == '0) ? '0 : i_q - IDX_W'(1);
    assign seqB_addr  = (j_q == '0) ? '0 : j_q - IDX_W'(1);

    assign en_traceB  = en_q;
    assign symbol     = sym_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign step_count = step_q;

endmodule
